// File: rtl/abc_seq_pkg.sv
// Shared types and defaults for the a/b/c burst sequencer.
// One burst is the a |=> b ##1 c stimulus pattern.
package abc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST_A = 2'd1,
        ST_B = 2'd2,
        ST_C = 2'd3
    } state_t;

    localparam int BURST_LEN = 3;

    localparam int DEF_NUM_REQ       = 2;
    localparam int DEF_WARMUP_CYCLES = 20;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/abc_seq_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the lowest requester at or above
// the pointer wins, else the lowest requester overall.
module rr_arbiter
    import abc_seq_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any_req
);

    logic [NUM_REQ-1:0] hi;

    always_comb begin
        hi      = '0;
        win     = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi[i] = req[i] && (i >= int'(ptr));
        end
        // Downward scans leave the lowest set index; the upper pass overrides.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win     = '0;
                win[i]  = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        if (|hi) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (hi[i]) begin
                    win     = '0;
                    win[i]  = 1'b1;
                    win_idx = IDX_W'(i);
                end
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/abc_seq_arbiter.sv
// Shares one a/b/c stimulus port among requesters, one 3-cycle burst
// per grant, and scores the DUT response d once warm-up has elapsed.
module abc_seq_arbiter
    import abc_seq_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               a,
    output logic               b,
    output logic               c,
    input  logic               d,
    output logic               chk_en,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   fail_count
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [15:0]      WARM_LAST = 16'(WARMUP_CYCLES);
    localparam logic [15:0]      WARM_PRE  = 16'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] owner;
    logic [NUM_REQ-1:0] owner_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic [15:0]        warm;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE, ST_C: begin
                if (any_req) begin
                    state_nxt = ST_A;
                    owner_nxt = win;
                    ptr_nxt   = (win_idx == IDX_W'(NUM_REQ - 1))
                              ? '0 : win_idx + 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ST_A: state_nxt = ST_B;
            ST_B: state_nxt = ST_C;
        endcase
    end

    always_comb begin
        a    = (state == ST_A);
        b    = (state == ST_B);
        c    = (state == ST_C);
        gnt  = (state != IDLE) ? owner : '0;
        done = (state == ST_C) ? owner : '0;
    end

    // Warm-up counter parks at its limit; chk_en then latches high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm   <= '0;
            chk_en <= 1'b0;
        end else if (warm < WARM_LAST) begin
            warm <= warm + 16'd1;
            if (warm == WARM_PRE) begin
                chk_en <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (state == ST_C && chk_en) begin
            if (d) begin
                if (pass_count != CNT_MAX) begin
                    pass_count <= pass_count + 1'b1;
                end
            end else begin
                if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_abc_seq_arbiter.sv
// Directed bench for abc_seq_arbiter: burst timing, warm-up edge,
// round-robin contention, dropped request, saturation, async reset.
module tb_abc_seq_arbiter;

    localparam int N  = 2;
    localparam int W  = 20;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          d = 1'b0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          a;
    logic          b;
    logic          c;
    logic          chk_en;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;

    int total = 0;
    int bad   = 0;

    abc_seq_arbiter #(
        .NUM_REQ       (N),
        .WARMUP_CYCLES (W),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .done       (done),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .chk_en     (chk_en),
        .pass_count (pass_count),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Packs {a,b,c,gnt,done} for compact burst-phase checks.
    function automatic logic [31:0] outs();
        return 32'({a, b, c, gnt, done});
    endfunction

    initial begin
        #12;
        check("rst_outs", outs(), 32'b000_00_00);
        check("rst_chk_en", 32'(chk_en), 0);
        check("rst_pass", 32'(pass_count), 0);
        check("rst_fail", 32'(fail_count), 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, checking disabled
        step();
        check("idle_e1", outs(), 32'b000_00_00);
        req = 2'b01;
        step();
        check("t1_a", outs(), 32'b100_01_00);
        req = 2'b00;
        step();
        check("t1_b", outs(), 32'b010_01_00);
        step();
        check("t1_c", outs(), 32'b001_01_01);
        d = 1'b1;
        step();
        check("t1_idle", outs(), 32'b000_00_00);
        check("t1_pass", 32'(pass_count), 0);
        check("t1_fail", 32'(fail_count), 0);

        // Burst whose c cycle ends at edge 19
        step(10);
        req = 2'b01;
        step();
        req = 2'b00;
        step(2);
        check("w19_c", outs(), 32'b001_01_01);
        check("w18_chk_en", 32'(chk_en), 0);
        step();
        check("w19_pass", 32'(pass_count), 0);
        check("w19_chk_en", 32'(chk_en), 0);
        step();
        check("w20_chk_en", 32'(chk_en), 1);

        // Burst whose c cycle ends at edge 25
        step();
        req = 2'b01;
        step();
        req = 2'b00;
        step(3);
        check("w25_pass", 32'(pass_count), 1);
        check("w25_fail", 32'(fail_count), 0);
        check("w25_idle", outs(), 32'b000_00_00);

        // req[1] drops during ST_A
        req = 2'b10;
        step();
        check("drop_a", outs(), 32'b100_10_00);
        req = 2'b00;
        step();
        check("drop_b", outs(), 32'b010_10_00);
        step();
        check("drop_c", outs(), 32'b001_10_10);
        step();
        check("drop_idle", outs(), 32'b000_00_00);
        check("drop_pass", 32'(pass_count), 2);

        // Contention with d alternating per burst
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr_a%0d", k), outs(),
                  (k % 2 == 0) ? 32'b100_01_00 : 32'b100_10_00);
            d = (k % 2 == 0);
            step(2);
            check($sformatf("rr_c%0d", k), outs(),
                  (k % 2 == 0) ? 32'b001_01_01 : 32'b001_10_10);
            if (k == 3) req = 2'b00;
        end
        step();
        check("rr_idle", outs(), 32'b000_00_00);
        check("rr_pass", 32'(pass_count), 4);
        check("rr_fail", 32'(fail_count), 2);

        // 17 passing back-to-back bursts saturate a 4-bit counter
        req = 2'b01;
        d   = 1'b1;
        step(51);
        check("sat_c", outs(), 32'b001_01_01);
        req = 2'b00;
        step();
        check("sat_idle", outs(), 32'b000_00_00);
        check("sat_pass", 32'(pass_count), 15);
        check("sat_fail", 32'(fail_count), 2);

        // Async reset while in ST_B
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        check("ar_b", outs(), 32'b010_01_00);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_outs", outs(), 32'b000_00_00);
        check("ar_pass", 32'(pass_count), 0);
        check("ar_fail", 32'(fail_count), 0);
        check("ar_chk_en", 32'(chk_en), 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(19);
        check("rw19_chk_en", 32'(chk_en), 0);
        step();
        check("rw20_chk_en", 32'(chk_en), 1);
        check("rw_pass", 32'(pass_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/abc_seq_arbiter.md
Name: abc_seq_arbiter

Overview:
- Shares one a/b/c stimulus port of the counttest-style assertion DUT among NUM_REQ requesters.
- Each grant drives one fixed 3-cycle burst: a, then b, then c. This is the a |=> b ##1 c pattern.
- Samples DUT output d on the c cycle and keeps saturating pass/fail counts.
- Counting is enabled only after a reset warm-up window, mirroring the pass-reporting-off warm-up used on the bench.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WARMUP_CYCLES, 20, posedges after reset release before chk_en rises (1..2^16-1).
- CNT_W, 16, width of pass/fail counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester burst request, level.
- gnt  output  NUM_REQ  one-hot owner, high for the whole burst.
- done  output  NUM_REQ  one-cycle pulse to the owner on its c cycle.
- a  output  1  DUT stimulus, burst cycle 1.
- b  output  1  DUT stimulus, burst cycle 2.
- c  output  1  DUT stimulus, burst cycle 3.
- d  input  1  DUT response, sampled on the c cycle.
- chk_en  output  1  high once warm-up has elapsed.
- pass_count  output  CNT_W  bursts with d=1 on c cycle while chk_en.
- fail_count  output  CNT_W  bursts with d=0 on c cycle while chk_en.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; gnt, done, a, b, c, chk_en = 0; counts = 0; rr pointer = 0; warm-up counter = 0.
- FSM states: IDLE, ST_A, ST_B, ST_C.
  - IDLE: if any req, pick a winner and go to ST_A; else stay.
  - ST_A -> ST_B -> ST_C, unconditional.
  - ST_C: if any req (including the current owner), pick a winner and go to ST_A (back-to-back bursts); else go to IDLE.
- All outputs are registered; each is a pure function of the state and owner registers.
  - a=1 only in ST_A; b=1 only in ST_B; c=1 only in ST_C.
  - gnt[owner]=1 in ST_A/ST_B/ST_C; gnt=0 in IDLE.
  - done[owner]=1 only in ST_C.
- Latency: req seen in IDLE at edge t -> a=1 and gnt valid after edge t; b follows 1 cycle later, c 2 cycles later.
- Arbitration (evaluated only in IDLE and ST_C):
  - Round-robin, starting from the rr pointer, lowest index first.
  - On each grant the pointer becomes winner+1 mod NUM_REQ.
  - A continuously requesting owner yields to any other pending requester.
- Requests:
  - req deassertion mid-burst does not abort; the burst always completes 3 cycles.
  - req of non-owners is ignored during ST_A/ST_B.
- Checking:
  - At the edge ending ST_C, if chk_en=1: d=1 increments pass_count, d=0 increments fail_count.
  - If chk_en=0, d is ignored.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Warm-up:
  - Counter increments every posedge after reset release.
  - chk_en rises after the WARMUP_CYCLES-th edge and then stays 1 until reset.
  - The warm-up counter stops at WARMUP_CYCLES.
- Reset asserted mid-burst: a/b/c/gnt drop immediately (async); no count update; no done pulse.
- X on req is treated as 0 by design intent; the bench never drives X.

Decomposition:
- Package abc_seq_pkg:
  - state enum typedef (IDLE, ST_A, ST_B, ST_C), 2-bit encoding.
  - BURST_LEN=3 localparam.
  - Default parameter constants.
- Sub-module rr_arbiter (NUM_REQ parameter), combinational:
  - Inputs: req, pointer. Outputs: one-hot winner, winner index, any_req.
  - The pointer register lives in abc_seq_arbiter.

Test Plan:
- Single requester, no warm-up wait: release rst_n, req[0]=1 at cycle 2 held 1 cycle.
  - Required: a@3, b@4, c@5; gnt=01 cycles 3-5; done[0]@5; chk_en=0 so both counts stay 0.
- Warm-up boundary (WARMUP_CYCLES=20): chk_en=0 through the 20th edge after reset and 1 from then on.
  - A burst whose c cycle ends at edge 19 with d=1 leaves pass_count=0.
  - A burst whose c ends at edge 25 with d=1 gives pass_count=1.
- Contention: req=11 continuously after warm-up, d alternating 1,0 per burst.
  - Required: grants alternate 01,10,01,10, back-to-back with no IDLE gap.
  - After 4 bursts: pass_count=2, fail_count=2.
- Request dropped mid-burst: req[1] rises then falls in ST_A.
  - Required: full a,b,c burst still produced; done[1] pulses; then IDLE.
- Async reset in ST_B: a/b/c/gnt go 0 without a clock edge; counts reset to 0; chk_en=0; warm-up restarts.
- Saturation (CNT_W=4): 17 passing bursts after warm-up -> pass_count stays at 15.
